// File: rtl/inverse_tone_mapping.sv
// Re-expands a (W-2)-bit tone-mapped pixel stream to the W-bit linear range
// using per-frame min/max anchors: data_o = min + floor(d*(max-min)/255).
module inverse_tone_mapping #(
  parameter int W   = 10,
  parameter int LAT = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           sop,
  input  logic           eop,
  input  logic           valid,
  input  logic [W-3:0]   data,
  input  logic [W-1:0]   min_i,
  input  logic [W-1:0]   max_i,
  output logic [W-1:0]   data_o,
  output logic           sop_o,
  output logic           eop_o,
  output logic           valid_o,
  output logic           frame_err,
  output logic [23:0]    pix_cnt
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [2*W-3:0] DIV = (2*W-2)'(255);

  state_t r_state, w_state_nxt;
  logic   w_acc, w_err, w_sop_acc, w_eop_acc;

  logic [W-1:0]   r_min, r_rng, w_rng_new, w_min_eff, w_rng_eff;
  logic [23:0]    r_cnt, w_cnt_nxt;

  logic [LAT:1]   r_vld, r_sop, r_eop;
  logic [LAT-1:1][23:0] r_cnt_pipe;

  logic [W-3:0]   r_d1;
  logic [W-1:0]   r_min1, r_rng1, r_min2, w_res;
  logic [2*W-3:0] r_p2;

  always_comb begin
    w_state_nxt = r_state;
    w_acc       = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: if (valid) begin
        if (sop) begin
          w_acc       = 1'b1;
          w_state_nxt = eop ? IDLE : ACTIVE;
        end else begin
          w_err = 1'b1;
        end
      end
      ACTIVE: if (valid) begin
        w_acc = 1'b1;
        w_err = sop;
        if (eop) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_sop_acc = w_acc & sop;
  assign w_eop_acc = w_acc & eop;
  assign w_rng_new = (max_i > min_i) ? (max_i - min_i) : '0;
  // The sop beat itself must already see the new anchors.
  assign w_min_eff = sop ? min_i : r_min;
  assign w_rng_eff = sop ? w_rng_new : r_rng;
  assign w_cnt_nxt = sop ? 24'd1 : ((r_cnt == '1) ? r_cnt : r_cnt + 24'd1);

  // Constant divide; the result is <= range, so it always fits in W bits.
  assign w_res = r_min2 + W'(r_p2 / DIV);

  assign valid_o = r_vld[LAT];
  assign sop_o   = r_sop[LAT];
  assign eop_o   = r_eop[LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_min      <= '0;
      r_rng      <= '0;
      r_cnt      <= '0;
      r_vld      <= '0;
      r_sop      <= '0;
      r_eop      <= '0;
      r_cnt_pipe <= '0;
      r_d1       <= '0;
      r_min1     <= '0;
      r_rng1     <= '0;
      r_min2     <= '0;
      r_p2       <= '0;
      frame_err  <= 1'b0;
      pix_cnt    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      frame_err <= w_err;
      if (w_sop_acc) begin
        r_min <= min_i;
        r_rng <= w_rng_new;
      end
      if (w_acc) begin
        r_cnt  <= w_cnt_nxt;
        r_d1   <= data;
        r_min1 <= w_min_eff;
        r_rng1 <= w_rng_eff;
      end
      r_vld[1]      <= w_acc;
      r_sop[1]      <= w_sop_acc;
      r_eop[1]      <= w_eop_acc;
      r_cnt_pipe[1] <= w_cnt_nxt;
      for (int k = 2; k <= LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_sop[k] <= r_sop[k-1];
        r_eop[k] <= r_eop[k-1];
      end
      for (int k = 2; k <= LAT-1; k++) r_cnt_pipe[k] <= r_cnt_pipe[k-1];
      r_p2   <= {{W{1'b0}}, r_d1} * {{(W-2){1'b0}}, r_rng1};
      r_min2 <= r_min1;
      // Count lands on the same edge that presents eop_o.
      if (r_vld[LAT-1] && r_eop[LAT-1]) pix_cnt <= r_cnt_pipe[LAT-1];
    end
  end

  // data_o only moves with a valid output beat and holds otherwise.
  if (LAT == 3) begin : g_out3
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      data_o <= '0;
      else if (r_vld[2]) data_o <= w_res;
    end
  end else begin : g_outn
    logic [LAT-1:3][W-1:0] r_dly;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_dly  <= '0;
        data_o <= '0;
      end else begin
        r_dly[3] <= w_res;
        for (int k = 4; k <= LAT-1; k++) r_dly[k] <= r_dly[k-1];
        if (r_vld[LAT-1]) data_o <= r_dly[LAT-1];
      end
    end
  end

endmodule

// File: tb/tb_inverse_tone_mapping.sv
// Directed bench for inverse_tone_mapping: scripted frames, captured outputs
// compared against hand-computed pixels, latency, framing and pix_cnt.
module tb_inverse_tone_mapping;
  localparam int W   = 10;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         sop, eop, valid;
  logic [W-3:0] data;
  logic [W-1:0] min_i, max_i;
  logic [W-1:0] data_o;
  logic         sop_o, eop_o, valid_o, frame_err;
  logic [23:0]  pix_cnt;

  inverse_tone_mapping #(.W(W), .LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .sop(sop), .eop(eop), .valid(valid),
    .data(data), .min_i(min_i), .max_i(max_i), .data_o(data_o),
    .sop_o(sop_o), .eop_o(eop_o), .valid_o(valid_o),
    .frame_err(frame_err), .pix_cnt(pix_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int d; bit s; bit e; int c; int pc; } rec_t;
  rec_t cap[$];
  rec_t exp_q[$];
  int   cyc = 0;
  int   errs = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (valid_o) cap.push_back('{int'(data_o), sop_o, eop_o, cyc, int'(pix_cnt)});
      if (frame_err) errs++;
    end
  end

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input bit s, input bit e, input int d, input int mn,
                      input int mx, input bit keep, input int xd, input int xpc);
    sop = s; eop = e; valid = 1'b1;
    data = (W-2)'(d); min_i = W'(mn); max_i = W'(mx);
    if (keep) exp_q.push_back('{xd, s, e, cyc + LAT, xpc});
    @(posedge clk); #1;
  endtask

  task automatic drain_check(input string tag, input int xerr);
    idle(LAT + 3);
    chk({tag, "_count"}, cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      chk({tag, "_data"}, cap[i].d, exp_q[i].d);
      chk({tag, "_sop"},  int'(cap[i].s), int'(exp_q[i].s));
      chk({tag, "_eop"},  int'(cap[i].e), int'(exp_q[i].e));
      chk({tag, "_lat"},  cap[i].c, exp_q[i].c);
      if (exp_q[i].e) chk({tag, "_pixcnt"}, cap[i].pc, exp_q[i].pc);
    end
    chk({tag, "_ferr"}, errs, xerr);
    cap.delete(); exp_q.delete(); errs = 0;
  endtask

  initial begin
    reset_n = 1'b0; sop = 1'b0; eop = 1'b0; valid = 1'b0;
    data = '0; min_i = '0; max_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data",  int'(data_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_sop",   int'(sop_o), 0);
    chk("rst_eop",   int'(eop_o), 0);
    chk("rst_ferr",  int'(frame_err), 0);
    chk("rst_pix",   int'(pix_cnt), 0);
    reset_n = 1'b1;
    idle(2);

    // Basic frame, range 800
    beat(1, 0, 0,   100, 900, 1, 100, 0);
    beat(0, 0, 255, 100, 900, 1, 900, 0);
    beat(0, 0, 128, 100, 900, 1, 501, 0);
    beat(0, 1, 1,   100, 900, 1, 103, 4);
    drain_check("basic", 0);
    chk("basic_pix_hold", int'(pix_cnt), 4);

    // Inverted anchors -> range 0, everything is min
    beat(1, 0, 0,   200, 50, 1, 200, 0);
    beat(0, 0, 200, 200, 50, 1, 200, 0);
    beat(0, 1, 255, 200, 50, 1, 200, 3);
    drain_check("inverted", 0);

    // Stray beat without sop is dropped, next frame unaffected
    beat(0, 0, 77, 0, 255, 0, 0, 0);
    idle(2);
    beat(1, 0, 10,  0, 255, 1, 10,  0);
    beat(0, 1, 200, 0, 255, 1, 200, 2);
    drain_check("drop", 1);

    // Mid-frame sop restarts with new anchors
    beat(1, 0, 255, 0,  1023, 1, 1023, 0);
    beat(0, 0, 0,   0,  1023, 1, 0,    0);
    beat(0, 0, 128, 0,  1023, 1, 513,  0);
    beat(1, 0, 255, 10, 20,   1, 20,   0);
    beat(0, 0, 0,   10, 20,   1, 10,   0);
    beat(0, 1, 128, 10, 20,   1, 15,   3);
    drain_check("restart", 1);

    // Single-beat frame followed by back-to-back frames
    beat(1, 1, 255, 0, 1023, 1, 1023, 1);
    beat(1, 0, 100, 0, 510,  1, 200,  0);
    beat(0, 1, 50,  0, 510,  1, 100,  2);
    beat(1, 1, 200, 5, 5,    1, 5,    1);
    drain_check("b2b", 0);

    // Async reset with pixels in flight
    beat(1, 0, 1, 0, 1023, 0, 0, 0);
    beat(0, 0, 2, 0, 1023, 0, 0, 0);
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_data",  int'(data_o), 0);
    chk("arst_valid", int'(valid_o), 0);
    chk("arst_sop",   int'(sop_o), 0);
    chk("arst_eop",   int'(eop_o), 0);
    chk("arst_ferr",  int'(frame_err), 0);
    chk("arst_pix",   int'(pix_cnt), 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    idle(8);
    chk("arst_stale", cap.size(), 0);
    chk("arst_errs", errs, 0);
    cap.delete(); errs = 0;

    // Exhaustive d sweep at range 1023
    for (int d = 0; d < 256; d++)
      beat(d == 0, d == 255, d, 0, 1023, 1, (d * 1023) / 255, 256);
    drain_check("sweep", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
